// File: rtl/ctrl_cmd_engine.sv
// Header-framed AXIS command processor (WRITE/READ/INC) over a register bank, one response packet per command.
// Optional stall watchdog enabled by defining CTRL_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module ctrl_cmd_engine #(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       inner_clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          s_tdata,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_stb_o,
    output logic                       busy_o
);
    localparam int          AW         = $clog2(NUM_REGS);
    localparam logic [AW:0] PTR_END    = (AW+1)'(NUM_REGS);
    localparam logic [7:0]  OP_WR      = 8'h01;
    localparam logic [7:0]  OP_RD      = 8'h02;
    localparam logic [7:0]  OP_INC     = 8'h03;
    localparam logic [7:0]  CODE_OK    = 8'h00;
    localparam logic [7:0]  CODE_BADOP = 8'h01;
    localparam logic [7:0]  CODE_BADAD = 8'h02;

    if (DATA_W < 32 || NUM_REGS < 2 || NUM_REGS > 256 || TIMEOUT_CYC < 1) begin : g_badParams
        $error("ctrl_cmd_engine: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, WR_DATA, INC_DATA, RD_DATA, DRAIN, STATUS} state_t;

    state_t            state_q, drainNext_q;
    logic [7:0]        op_q, tag_q, len_q, code_q, count_q;
    logic [AW:0]       ptr_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] mData_q;
    logic              mValid_q, mLast_q, wrStb_q, alive_q;

    logic              slotFree, accept, hdrAddrBad, ptrOk;
    logic [7:0]        hdrOp, hdrTag, hdrLen, hdrAddr, countInc;
    logic [AW:0]       hdrPtr, ptrInc;
    logic [DATA_W-1:0] statusWord;

    assign slotFree   = !mValid_q || m_tready;
    assign hdrOp      = s_tdata[31:24];
    assign hdrTag     = s_tdata[23:16];
    assign hdrLen     = s_tdata[15:8];
    assign hdrAddr    = s_tdata[7:0];
    assign hdrAddrBad = {1'b0, hdrAddr} >= 9'(NUM_REGS);
    // Out-of-range start addresses park the pointer at the end so it can never wrap back in range.
    assign hdrPtr     = hdrAddrBad ? PTR_END : (AW+1)'(hdrAddr);
    assign ptrOk      = ptr_q < PTR_END;
    assign ptrInc     = ptrOk ? ptr_q + (AW+1)'(1) : ptr_q;
    assign countInc   = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    assign statusWord = DATA_W'({op_q, tag_q, code_q, count_q});

    always_comb begin
        s_tready = 1'b0;
        case (state_q)
            IDLE, WR_DATA, DRAIN: s_tready = alive_q;
            INC_DATA:             s_tready = alive_q && slotFree;
            default:              s_tready = 1'b0;
        endcase
    end
    assign accept = s_tvalid && s_tready;

`ifdef CTRL_TIMEOUT_EN
    localparam int             SW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0]  STALL_MAX = SW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     CODE_TIMEOUT = 8'h03;
    logic [SW-1:0] stall_q;
`endif

    always_ff @(posedge inner_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drainNext_q <= IDLE;
            op_q        <= '0;
            tag_q       <= '0;
            len_q       <= '0;
            code_q      <= '0;
            count_q     <= '0;
            ptr_q       <= '0;
            mData_q     <= '0;
            mValid_q    <= 1'b0;
            mLast_q     <= 1'b0;
            wrStb_q     <= 1'b0;
            alive_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef CTRL_TIMEOUT_EN
            stall_q     <= '0;
`endif
        end else begin
            alive_q <= 1'b1;
            wrStb_q <= 1'b0;
            if (m_tready) mValid_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    op_q    <= hdrOp;
                    tag_q   <= hdrTag;
                    len_q   <= hdrLen;
                    ptr_q   <= hdrPtr;
                    count_q <= '0;
                    code_q  <= CODE_OK;
                    case (hdrOp)
                        OP_WR:  state_q <= s_tlast ? STATUS : WR_DATA;
                        OP_INC: state_q <= s_tlast ? STATUS : INC_DATA;
                        OP_RD: begin
                            // Single-beat reads issue the first word straight from the header cycle.
                            if (!s_tlast) begin
                                state_q     <= DRAIN;
                                drainNext_q <= RD_DATA;
                            end else if (hdrLen == 8'd0) begin
                                state_q <= STATUS;
                            end else if (hdrAddrBad) begin
                                code_q  <= CODE_BADAD;
                                state_q <= STATUS;
                            end else if (slotFree) begin
                                mData_q  <= regs_q[hdrAddr[AW-1:0]];
                                mLast_q  <= 1'b0;
                                mValid_q <= 1'b1;
                                ptr_q    <= hdrPtr + (AW+1)'(1);
                                count_q  <= 8'd1;
                                state_q  <= (hdrLen == 8'd1) ? STATUS : RD_DATA;
                            end else begin
                                state_q <= RD_DATA;
                            end
                        end
                        default: begin
                            code_q      <= CODE_BADOP;
                            drainNext_q <= STATUS;
                            state_q     <= s_tlast ? STATUS : DRAIN;
                        end
                    endcase
                end
                WR_DATA: if (accept) begin
                    if (ptrOk) begin
                        regs_q[ptr_q[AW-1:0]] <= s_tdata;
                        wrStb_q <= 1'b1;
                        count_q <= countInc;
                    end else begin
                        code_q <= CODE_BADAD;
                    end
                    ptr_q <= ptrInc;
                    if (s_tlast) state_q <= STATUS;
                end
                INC_DATA: if (accept) begin
                    mData_q  <= s_tdata + DATA_W'(1);
                    mLast_q  <= 1'b0;
                    mValid_q <= 1'b1;
                    count_q  <= countInc;
                    if (s_tlast) state_q <= STATUS;
                end
                RD_DATA: begin
                    if (count_q == len_q) begin
                        state_q <= STATUS;
                    end else if (!ptrOk) begin
                        code_q  <= CODE_BADAD;
                        state_q <= STATUS;
                    end else if (slotFree) begin
                        mData_q  <= regs_q[ptr_q[AW-1:0]];
                        mLast_q  <= 1'b0;
                        mValid_q <= 1'b1;
                        ptr_q    <= ptrInc;
                        count_q  <= countInc;
                        if (countInc == len_q) state_q <= STATUS;
                    end
                end
                DRAIN: if (accept && s_tlast) state_q <= drainNext_q;
                STATUS: if (slotFree) begin
                    mData_q  <= statusWord;
                    mLast_q  <= 1'b1;
                    mValid_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef CTRL_TIMEOUT_EN
            // Watchdog only fires on idle input cycles, so it never collides with a beat being consumed.
            if (state_q inside {WR_DATA, INC_DATA, DRAIN}) begin
                if (s_tvalid) begin
                    stall_q <= '0;
                end else if (stall_q == STALL_MAX) begin
                    stall_q <= '0;
                    code_q  <= CODE_TIMEOUT;
                    state_q <= STATUS;
                end else begin
                    stall_q <= stall_q + SW'(1);
                end
            end else begin
                stall_q <= '0;
            end
`endif
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        assign regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign m_tdata  = mData_q;
    assign m_tvalid = mValid_q;
    assign m_tlast  = mLast_q;
    assign wr_stb_o = wrStb_q;
    assign busy_o   = (state_q != IDLE);
endmodule

// File: tb/tb_ctrl_cmd_engine.sv
// Self-checking bench for ctrl_cmd_engine: directed command packets plus randomized traffic/backpressure
// against a packet-level reference model; watchdog behaviour follows CTRL_TIMEOUT_EN.
module tb_ctrl_cmd_engine;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int TO = 16;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tlast = 1'b0;
    logic              s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready = 1'b0;
    logic [NR*DW-1:0]  regs_o;
    logic              wr_stb_o;
    logic              busy_o;

    int          nCompared = 0;
    int          nMismatch = 0;
    int          cyc = 0;
    int          stbCount = 0;
    int          readyPct = 100;
    int          firstValidCyc = -1;
    beat_t       gotQ[$];
    logic [31:0] mregs [NR];

    ctrl_cmd_engine #(.DATA_W(DW), .NUM_REGS(NR), .TIMEOUT_CYC(TO)) dut (
        .inner_clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .regs_o(regs_o), .wr_stb_o(wr_stb_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response sink: picks m_tready for the coming edge and logs every handshake that edge will perform.
    always @(negedge clk) begin
        m_tready = (readyPct >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyPct);
        if (m_tvalid && m_tready) gotQ.push_back('{m_tdata, m_tlast});
        if (wr_stb_o) stbCount++;
        if (m_tvalid && firstValidCyc < 0) firstValidCyc = cyc;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] hdr(input logic [7:0] op, tag, len, addr);
        return {op, tag, len, addr};
    endfunction

    // Packet-level reference: applies one command to the model bank and appends its response beats.
    function automatic void modelPacket(input logic [31:0] pkt[$], inout beat_t exp[$], inout int nWr);
        logic [7:0] op, tag, len, addr, code;
        int cnt, a;
        op = pkt[0][31:24]; tag = pkt[0][23:16]; len = pkt[0][15:8]; addr = pkt[0][7:0];
        code = 8'h00; cnt = 0;
        case (op)
            8'h01: for (int i = 1; i < pkt.size(); i++) begin
                a = int'(addr) + i - 1;
                if (a < NR) begin mregs[a] = pkt[i]; cnt++; nWr++; end
                else code = 8'h02;
            end
            8'h02: for (int i = 0; i < int'(len); i++) begin
                a = int'(addr) + i;
                if (a >= NR) begin code = 8'h02; break; end
                exp.push_back('{mregs[a], 1'b0});
                cnt++;
            end
            8'h03: for (int i = 1; i < pkt.size(); i++) begin
                exp.push_back('{pkt[i] + 32'd1, 1'b0});
                cnt++;
            end
            default: code = 8'h01;
        endcase
        if (cnt > 255) cnt = 255;
        exp.push_back('{{op, tag, code, 8'(cnt)}, 1'b1});
    endfunction

    function automatic logic [NR*DW-1:0] modelRegs();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = mregs[i];
        return v;
    endfunction

    function automatic int countLast();
        int n = 0;
        foreach (gotQ[i]) if (gotQ[i].l) n++;
        return n;
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    task automatic sendBeat(input logic [31:0] d, input logic l, output int acc);
        int guard = 0;
        @(negedge clk);
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        #1;
        while (!s_tready && guard < 2000) begin
            @(negedge clk); #1; guard++;
        end
        if (guard >= 2000) begin
            nCompared++; nMismatch++;
            $display("[TB] FAIL s_tready_timeout: beat %h never accepted", d);
        end
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic waitResponse(input int nLast, input int budget);
        int n = 0;
        while (countLast() < nLast && n < budget) begin
            @(negedge clk); n++;
        end
        if (countLast() < nLast) begin
            nCompared++; nMismatch++;
            $display("[TB] FAIL response_timeout: got %0d trailers, want %0d", countLast(), nLast);
        end
    endtask

    // Sends one or more packets (flattened words + per-packet lengths) and checks the whole response stream.
    task automatic runPacket(input logic [31:0] words[$], input int lens[$], input int gapMax,
                             input int latMode, input string name);
        beat_t       exp[$];
        logic [31:0] pkt[$];
        int          acc[$];
        int          nWr = 0, base = 0, a, refCyc;
        foreach (lens[k]) begin
            pkt.delete();
            for (int j = 0; j < lens[k]; j++) pkt.push_back(words[base + j]);
            modelPacket(pkt, exp, nWr);
            base += lens[k];
        end
        gotQ.delete(); stbCount = 0; firstValidCyc = -1;
        base = 0;
        foreach (lens[k]) begin
            for (int j = 0; j < lens[k]; j++) begin
                if (gapMax > 0 && (base + j) > 0) idleCycles($urandom_range(0, gapMax));
                sendBeat(words[base + j], (j == lens[k] - 1), a);
                acc.push_back(a);
            end
            base += lens[k];
        end
        idleCycles(1);
        waitResponse(lens.size(), 4000);
        idleCycles(4);
        nCompared++;
        if (gotQ.size() != exp.size()) begin
            nMismatch++;
            $display("[TB] FAIL %s beat_count: got %0d want %0d", name, gotQ.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < gotQ.size(); i++) begin
            nCompared++;
            if (gotQ[i].d !== exp[i].d || gotQ[i].l !== exp[i].l) begin
                nMismatch++;
                $display("[TB] FAIL %s beat%0d: got %h/%b want %h/%b", name, i,
                         gotQ[i].d, gotQ[i].l, exp[i].d, exp[i].l);
            end
        end
        nCompared++;
        if (stbCount != nWr) begin
            nMismatch++;
            $display("[TB] FAIL %s wr_stb: got %0d want %0d", name, stbCount, nWr);
        end
        nCompared++;
        if (regs_o !== modelRegs()) begin
            nMismatch++;
            $display("[TB] FAIL %s regs: got %h want %h", name, regs_o, modelRegs());
        end
        if (latMode != 0) begin
            refCyc = (latMode == 1) ? acc[0] : (latMode == 2) ? acc[1] : acc[lens[0] - 1] + 1;
            nCompared++;
            if (firstValidCyc != refCyc) begin
                nMismatch++;
                $display("[TB] FAIL %s latency: first valid at %0d want %0d", name, firstValidCyc, refCyc);
            end
        end
    endtask

    task automatic checkIdleOutputs(input string name);
        nCompared++;
        if (m_tvalid !== 1'b0 || busy_o !== 1'b0 || wr_stb_o !== 1'b0 || regs_o !== '0) begin
            nMismatch++;
            $display("[TB] FAIL %s: valid=%b busy=%b stb=%b regs=%h want all 0",
                     name, m_tvalid, busy_o, wr_stb_o, regs_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idleCycles(3);
        checkIdleOutputs("reset_outputs");
        nCompared++;
        if (s_tready !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0) begin
            nMismatch++;
            $display("[TB] FAIL reset_stream: s_tready=%b m_tlast=%b m_tdata=%h want 0", s_tready, m_tlast, m_tdata);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        idleCycles(2);
        nCompared++;
        if (s_tready !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL idle_ready: got %b want 1", s_tready);
        end
    endtask

    task automatic test_directed();
        readyPct = 100;
        runPacket('{hdr(8'h01, 8'h5A, 8'h00, 8'h02), 32'h11, 32'h22, 32'h33}, '{4}, 0, 3, "write_basic");
        runPacket('{hdr(8'h02, 8'h07, 8'h03, 8'h02)}, '{1}, 0, 1, "read_basic");
        runPacket('{hdr(8'h03, 8'h01, 8'h00, 8'h00), 32'hFFFF_FFFF, 32'h0000_0009}, '{3}, 0, 2, "inc_wrap");
        runPacket('{hdr(8'h7F, 8'h00, 8'h00, 8'h00), 32'hA, 32'hB, 32'hC}, '{4}, 0, 0, "bad_op_drain");
        runPacket('{hdr(8'h01, 8'h3C, 8'h00, 8'h0E), 32'hE0, 32'hF0, 32'h100, 32'h110}, '{5}, 0, 0, "write_bad_addr");
        runPacket('{hdr(8'h02, 8'h3D, 8'h04, 8'h0E)}, '{1}, 0, 0, "read_bad_addr");
        runPacket('{hdr(8'h02, 8'h3E, 8'h00, 8'h03)}, '{1}, 0, 0, "read_len0");
        runPacket('{hdr(8'h02, 8'h3F, 8'h02, 8'h20), 32'h1}, '{2}, 0, 0, "read_drain_oob");
        runPacket('{hdr(8'h00, 8'h40, 8'h00, 8'h00)}, '{1}, 0, 0, "bad_op_single");
    endtask

    task automatic randomPacket(inout logic [31:0] words[$], inout int lens[$]);
        int sel, nData;
        logic [7:0] op;
        sel = $urandom_range(0, 9);
        op = (sel < 3) ? 8'h01 : (sel < 6) ? 8'h02 : (sel < 9) ? 8'h03 : 8'(8'h10 + $urandom_range(0, 200));
        nData = $urandom_range(0, 4);
        words.push_back(hdr(op, 8'($urandom), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 19))));
        for (int i = 0; i < nData; i++) words.push_back($urandom);
        lens.push_back(nData + 1);
    endtask

    task automatic test_random_backpressure();
        logic [31:0] words[$];
        int          lens[$];
        for (int p = 0; p < 40; p++) begin
            words.delete(); lens.delete();
            readyPct = $urandom_range(30, 90);
            randomPacket(words, lens);
            runPacket(words, lens, 2, 0, $sformatf("random%0d", p));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[$];
        int          lens[$];
        for (int r = 0; r < 6; r++) begin
            words.delete(); lens.delete();
            readyPct = (r < 2) ? 100 : $urandom_range(40, 80);
            for (int p = 0; p < 4; p++) randomPacket(words, lens);
            runPacket(words, lens, 0, 0, $sformatf("b2b%0d", r));
        end
    endtask

    task automatic test_mid_reset();
        int a;
        logic [31:0] d;
        readyPct = 0;
        idleCycles(2);
        gotQ.delete();
        d = $urandom;
        sendBeat(hdr(8'h03, 8'h55, 8'h00, 8'h00), 1'b0, a);
        sendBeat(d, 1'b0, a);
        idleCycles(3);
        nCompared++;
        if (m_tvalid !== 1'b1 || m_tdata !== d + 32'd1 || m_tlast !== 1'b0 || busy_o !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL stall_hold: valid=%b data=%h last=%b busy=%b want 1/%h/0/1",
                     m_tvalid, m_tdata, m_tlast, busy_o, d + 32'd1);
        end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        @(negedge clk);
        checkIdleOutputs("mid_reset_outputs");
        readyPct = 100;
        idleCycles(6);
        nCompared++;
        if (gotQ.size() != 0) begin
            nMismatch++;
            $display("[TB] FAIL mid_reset_leak: got %0d beats want 0", gotQ.size());
        end
        runPacket('{hdr(8'h01, 8'h66, 8'h00, 8'h00), 32'hCAFE, 32'hBEEF}, '{3}, 0, 3, "post_reset_write");
        runPacket('{hdr(8'h02, 8'h67, 8'h03, 8'h00)}, '{1}, 0, 1, "post_reset_read");
    endtask

`ifdef CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int a;
        logic [31:0] d;
        readyPct = 100;
        gotQ.delete(); stbCount = 0;
        d = $urandom;
        sendBeat(hdr(8'h01, 8'h33, 8'h00, 8'h05), 1'b0, a);
        sendBeat(d, 1'b0, a);
        mregs[5] = d;
        idleCycles(12);
        nCompared++;
        if (gotQ.size() != 0 || busy_o !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL early_timeout: beats=%0d busy=%b want 0/1", gotQ.size(), busy_o);
        end
        waitResponse(1, 40);
        idleCycles(3);
        nCompared++;
        if (gotQ.size() != 1 || gotQ[0].d !== 32'h0133_0301 || gotQ[0].l !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL timeout_status: got %0d beats first %h want 1 beat 01330301",
                     gotQ.size(), (gotQ.size() > 0) ? gotQ[0].d : 32'h0);
        end
        nCompared++;
        if (stbCount != 1 || regs_o !== modelRegs() || busy_o !== 1'b0) begin
            nMismatch++;
            $display("[TB] FAIL timeout_state: stb=%0d busy=%b regs=%h want 1/0/%h", stbCount, busy_o, regs_o, modelRegs());
        end
    endtask
`else
    task automatic test_no_timeout();
        int a;
        logic [31:0] d0, d1;
        readyPct = 100;
        gotQ.delete(); stbCount = 0;
        d0 = $urandom; d1 = $urandom;
        sendBeat(hdr(8'h01, 8'h44, 8'h00, 8'h08), 1'b0, a);
        sendBeat(d0, 1'b0, a);
        idleCycles(40);
        nCompared++;
        if (gotQ.size() != 0 || busy_o !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL stall_wait: beats=%0d busy=%b want 0/1", gotQ.size(), busy_o);
        end
        sendBeat(d1, 1'b1, a);
        mregs[8] = d0; mregs[9] = d1;
        idleCycles(1);
        waitResponse(1, 40);
        idleCycles(3);
        nCompared++;
        if (gotQ.size() != 1 || gotQ[0].d !== 32'h0144_0002 || gotQ[0].l !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL stall_status: got %0d beats first %h want 1 beat 01440002",
                     gotQ.size(), (gotQ.size() > 0) ? gotQ[0].d : 32'h0);
        end
        nCompared++;
        if (stbCount != 2 || regs_o !== modelRegs()) begin
            nMismatch++;
            $display("[TB] FAIL stall_regs: stb=%0d regs=%h want 2/%h", stbCount, regs_o, modelRegs());
        end
    endtask
`endif

    initial begin
        $display("[TB] ctrl_cmd_engine bench start");
        test_reset();
        test_directed();
        test_random_backpressure();
        test_back_to_back();
`ifdef CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
